// File: rtl/clk_freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// clk_freq_meter_pkg
// Shared definitions for the clock frequency meter: FSM state encoding,
// default widths and the legal synchronizer depth range.
// Optional feature macro used by the other files: CLK_FREQ_METER_PERIOD_EN
// -----------------------------------------------------------------------------
package clk_freq_meter_pkg;

  localparam int DEF_WIN_W  = 16;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_SYNC_N = 2;
  localparam int SYNC_N_MIN = 2;
  localparam int SYNC_N_MAX = 4;

  // Width of the SETTLE cycle counter; must hold SYNC_N_MAX.
  localparam int SETTLE_W = $clog2(SYNC_N_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/clk_freq_meter_if.sv
// -----------------------------------------------------------------------------
// clk_freq_meter_if
// Request/result bus of the clock frequency meter.
//   master : requester (drives v_i, window_i, yumi_i)
//   slave  : the meter  (drives ready_o, v_o, count_o, ovf_o, state_o[, min_per_o])
// Handshake: a request is accepted in a cycle where v_i & ready_o; ready_o is
// high only while the meter is idle, and v_i at any other time is ignored.
// A result is offered with v_o and held (with count_o/ovf_o stable) until the
// consumer pulses yumi_i; yumi_i is only legal while v_o is high.
// state_o exposes the FSM state for observation.
// CLK_FREQ_METER_PERIOD_EN adds min_per_o (valid with v_o).
// -----------------------------------------------------------------------------
interface clk_freq_meter_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);
  logic             v_i;
  logic [WIN_W-1:0] window_i;
  logic             ready_o;
  logic             v_o;
  logic [CNT_W-1:0] count_o;
  logic             ovf_o;
  logic             yumi_i;
  logic [1:0]       state_o;
`ifdef CLK_FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] min_per_o;

  modport master (
    output v_i, window_i, yumi_i,
    input  ready_o, v_o, count_o, ovf_o, state_o, min_per_o
  );
  modport slave (
    input  v_i, window_i, yumi_i,
    output ready_o, v_o, count_o, ovf_o, state_o, min_per_o
  );
`else
  modport master (
    output v_i, window_i, yumi_i,
    input  ready_o, v_o, count_o, ovf_o, state_o
  );
  modport slave (
    input  v_i, window_i, yumi_i,
    output ready_o, v_o, count_o, ovf_o, state_o
  );
`endif
endinterface

// File: rtl/clk_freq_meter_sync.sv
// -----------------------------------------------------------------------------
// clk_freq_meter_sync
// SYNC_N-stage synchronizer for the asynchronous measured signal followed by
// one history flop; rise_o flags a synchronized 0->1 transition (at most one
// per clk_i cycle).
// Ports:
//   clk_i      system clock
//   reset_n_i  asynchronous active-low reset (all flops cleared to 0)
//   meas_i     signal under measurement, asynchronous to clk_i
//   rise_o     one-cycle rising-edge flag in the clk_i domain
// -----------------------------------------------------------------------------
module clk_freq_meter_sync
  import clk_freq_meter_pkg::*;
#(
  parameter int SYNC_N = DEF_SYNC_N
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic meas_i,
  output logic rise_o
);

  logic [SYNC_N-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_N-2:0], meas_i};
      r_hist <= r_sync[SYNC_N-1];
    end
  end

  assign rise_o = r_sync[SYNC_N-1] & ~r_hist;

endmodule

// File: rtl/clk_freq_meter.sv
// -----------------------------------------------------------------------------
// clk_freq_meter
// Counts rising edges of an asynchronous signal over a programmed window of
// window_i+1 system clock cycles and returns the count.
// Flow: IDLE -> SETTLE (SYNC_N+1 cycles, synchronizer flush, edges ignored)
//       -> COUNT (window_i+1 cycles) -> DONE (result held until yumi_i).
// Ports:
//   clk_i      system clock, the only clock
//   reset_n_i  asynchronous active-low reset; aborts any measurement
//   meas_i     signal under measurement (data only, never a clock)
//   bus        clk_freq_meter_if.slave: v_i/window_i/ready_o request side,
//              v_o/count_o/ovf_o/yumi_i result side, state_o observation
// Optional: CLK_FREQ_METER_PERIOD_EN adds bus.min_per_o, the smallest
// distance in clk_i cycles between consecutive rises seen in COUNT.
// -----------------------------------------------------------------------------
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int WIN_W  = DEF_WIN_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SYNC_N = DEF_SYNC_N
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              meas_i,
  clk_freq_meter_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETTLE = SETTLE;
  localparam logic [1:0] S_COUNT  = COUNT;
  localparam logic [1:0] S_DONE   = DONE;

  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_N);

  logic [1:0]          r_state;
  logic [WIN_W-1:0]    r_win;
  logic [SETTLE_W-1:0] r_settle;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;
  logic                w_rise;
  logic                w_accept;

  clk_freq_meter_sync #(
    .SYNC_N (SYNC_N)
  ) u_sync (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .meas_i    (meas_i),
    .rise_o    (w_rise)
  );

  assign w_accept = bus.v_i & (r_state == S_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= S_IDLE;
      r_win    <= '0;
      r_settle <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_SETTLE;
            r_win    <= bus.window_i;
            r_settle <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
          end
        end
        S_SETTLE: begin
          // r_settle runs 0..SYNC_N, giving SYNC_N+1 cycles in SETTLE.
          if (r_settle == SETTLE_LAST) begin
            r_state <= S_COUNT;
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        S_COUNT: begin
          if (w_rise) begin
            if (r_count != CNT_MAX) begin
              r_count <= r_count + CNT_ONE;
            end
            // ovf marks that the counter reached its saturation value.
            if (r_count >= (CNT_MAX - CNT_ONE)) begin
              r_ovf <= 1'b1;
            end
          end
          // Terminal test on zero before decrementing: an all-ones window
          // counts all the way down and never wraps.
          if (r_win == '0) begin
            r_state <= S_DONE;
          end else begin
            r_win <= r_win - WIN_W'(1);
          end
        end
        S_DONE: begin
          if (bus.yumi_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o = (r_state == S_IDLE);
  assign bus.v_o     = (r_state == S_DONE);
  assign bus.count_o = r_count;
  assign bus.ovf_o   = r_ovf;
  assign bus.state_o = r_state;

`ifdef CLK_FREQ_METER_PERIOD_EN
  // r_gap counts cycles since the last rise; the distance to the next rise
  // is r_gap+1. r_seen gates the first rise, which has no predecessor.
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_min_per;
  logic             r_seen;
  logic [CNT_W-1:0] w_gap_inc;

  assign w_gap_inc = (r_gap == CNT_MAX) ? CNT_MAX : (r_gap + CNT_ONE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_gap     <= '0;
      r_min_per <= '1;
      r_seen    <= 1'b0;
    end else if (w_accept) begin
      r_gap     <= '0;
      r_min_per <= '1;
      r_seen    <= 1'b0;
    end else if (r_state == S_COUNT) begin
      if (w_rise) begin
        if (r_seen && (w_gap_inc < r_min_per)) begin
          r_min_per <= w_gap_inc;
        end
        r_seen <= 1'b1;
        r_gap  <= '0;
      end else begin
        r_gap <= w_gap_inc;
      end
    end
  end

  assign bus.min_per_o = r_min_per;
`endif

endmodule
